csr_mport_unit: RTL and testbench



---
 rtl/csr_mport_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_csr_mport_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_mport_unit.sv
// csr_mport_unit: round-robin arbiter + serial CSR read-modify-write, accept->rd T+1, wr/push T+2, rsp T+3.
// Holds in EXEC (no write/unlock) while the response FIFO is full; CSR_FENCE_EN adds the warp drain before FPU CSRs.

module csr_mport_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign head_dat_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module csr_mport_unit #(
  parameter int                   NUM_REQS       = 2,
  parameter int                   XLEN           = 32,
  parameter int                   NW_BITS        = 2,
  parameter int                   ADDR_BITS      = 12,
  parameter int                   TAG_W          = 16,
  parameter int                   RSP_DEPTH      = 4,
  parameter logic [ADDR_BITS-1:0] FENCE_ADDR_MAX = 'h003,
  localparam int                  IDXW           = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  req_valid,
  output logic [NUM_REQS-1:0]                  req_ready,
  input  logic [NUM_REQS-1:0][NW_BITS-1:0]     req_wid,
  input  logic [NUM_REQS-1:0][ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQS-1:0][1:0]             req_op,
  input  logic [NUM_REQS-1:0]                  req_use_imm,
  input  logic [NUM_REQS-1:0][4:0]             req_imm,
  input  logic [NUM_REQS-1:0][XLEN-1:0]        req_rs1,
  input  logic [NUM_REQS-1:0][TAG_W-1:0]       req_tag,
  output logic [NW_BITS-1:0]                   alm_empty_wid,
  input  logic                                 alm_empty,
  output logic                                 unlock_valid,
  output logic [NW_BITS-1:0]                   unlock_wid,
  output logic                                 csr_rd_en,
  output logic [ADDR_BITS-1:0]                 csr_rd_addr,
  input  logic [XLEN-1:0]                      csr_rd_data,
  output logic                                 csr_wr_en,
  output logic [ADDR_BITS-1:0]                 csr_wr_addr,
  output logic [XLEN-1:0]                      csr_wr_data,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [XLEN-1:0]                      rsp_data,
  output logic [TAG_W-1:0]                     rsp_tag,
  output logic [IDXW-1:0]                      rsp_idx
);
  typedef enum logic [1:0] {S_IDLE, S_FENCE, S_READ, S_EXEC} state_e;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    logic [IDXW-1:0]  idx;
  } rsp_t;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       rr_ptr_q, grant_idx, idx_q;
  logic                  grant_vld, grant_fence, accept, push, pop;
  logic [NW_BITS-1:0]    wid_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [1:0]            op_q;
  logic                  use_imm_q, fence_q, rd_pend_q;
  logic [4:0]            imm_q;
  logic [XLEN-1:0]       rs1_q, hold_q, rdata, src, wdata;
  logic [TAG_W-1:0]      tag_q;
  logic                  wen, fifo_full, fifo_empty;
  rsp_t                  push_dat, head_dat;

  function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] base, input int off);
    return IDXW'((int'(base) + off) % NUM_REQS);
  endfunction

  // Walk from farthest to nearest so the channel right after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (req_valid[rr_idx(rr_ptr_q, i + 1)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx(rr_ptr_q, i + 1);
      end
    end
  end

  assign grant_fence = (req_addr[grant_idx] <= FENCE_ADDR_MAX);

  // Read data is only live the cycle after csr_rd_en; later EXEC cycles use the held copy.
  assign rdata = rd_pend_q ? csr_rd_data : hold_q;
  assign src   = use_imm_q ? {{(XLEN-5){1'b0}}, imm_q} : rs1_q;
  assign wen   = (op_q == 2'b00) | (src != '0);

  always_comb begin
    case (op_q)
      2'b00:   wdata = src;
      2'b01:   wdata = rdata | src;
      default: wdata = rdata & ~src;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = '0;
    accept        = 1'b0;
    push          = 1'b0;
    csr_rd_en     = 1'b0;
    csr_rd_addr   = '0;
    csr_wr_en     = 1'b0;
    csr_wr_addr   = '0;
    csr_wr_data   = '0;
    alm_empty_wid = '0;
    unlock_valid  = 1'b0;
    unlock_wid    = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          accept               = 1'b1;
          req_ready[grant_idx] = 1'b1;
`ifdef CSR_FENCE_EN
          state_d = grant_fence ? S_FENCE : S_READ;
`else
          state_d = S_READ;
`endif
        end
      end
      S_FENCE: begin
`ifdef CSR_FENCE_EN
        alm_empty_wid = wid_q;
        if (alm_empty) state_d = S_READ;
`else
        state_d = S_READ;
`endif
      end
      S_READ: begin
        csr_rd_en   = 1'b1;
        csr_rd_addr = addr_q;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        if (!fifo_full) begin
          push      = 1'b1;
          csr_wr_en = wen;
          if (wen) begin
            csr_wr_addr = addr_q;
            csr_wr_data = wdata;
          end
`ifdef CSR_FENCE_EN
          unlock_valid = fence_q;
          if (fence_q) unlock_wid = wid_q;
`endif
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= IDXW'(NUM_REQS - 1);
      idx_q     <= '0;
      wid_q     <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      rs1_q     <= '0;
      tag_q     <= '0;
      fence_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= (state_q == S_READ);
      if (state_q == S_EXEC) hold_q <= rdata;
      if (accept) begin
        rr_ptr_q  <= grant_idx;
        idx_q     <= grant_idx;
        wid_q     <= req_wid[grant_idx];
        addr_q    <= req_addr[grant_idx];
        op_q      <= req_op[grant_idx];
        use_imm_q <= req_use_imm[grant_idx];
        imm_q     <= req_imm[grant_idx];
        rs1_q     <= req_rs1[grant_idx];
        tag_q     <= req_tag[grant_idx];
        fence_q   <= grant_fence;
      end
    end
  end

`ifndef CSR_FENCE_EN
  logic unused_fence;
  assign unused_fence = ^{alm_empty, wid_q, fence_q};
`endif

  assign push_dat = '{data: rdata, tag: tag_q, idx: idx_q};
  assign pop      = rsp_valid & rsp_ready;

  csr_mport_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = rsp_valid ? head_dat.data : '0;
  assign rsp_tag   = rsp_valid ? head_dat.tag  : '0;
  assign rsp_idx   = rsp_valid ? head_dat.idx  : '0;
endmodule

// File: tb/tb_csr_mport_unit.sv
// Directed bench for csr_mport_unit: vector table for single requests plus sequences for
// arbitration, fence drain, FIFO-full hold and mid-operation reset.
module tb_csr_mport_unit;
  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid, req_ready, req_use_imm;
  logic [1:0][1:0]   req_wid;
  logic [1:0][11:0]  req_addr;
  logic [1:0][1:0]   req_op;
  logic [1:0][4:0]   req_imm;
  logic [1:0][31:0]  req_rs1;
  logic [1:0][15:0]  req_tag;
  logic [1:0]        alm_empty_wid, unlock_wid;
  logic              alm_empty, unlock_valid;
  logic              csr_rd_en, csr_wr_en;
  logic [11:0]       csr_rd_addr, csr_wr_addr;
  logic [31:0]       csr_rd_data, csr_wr_data;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_data;
  logic [15:0]       rsp_tag;
  logic [0:0]        rsp_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int unl_cnt = 0;
  logic [31:0] cur_init = 32'h0;

  csr_mport_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_addr(req_addr),
    .req_op(req_op), .req_use_imm(req_use_imm), .req_imm(req_imm), .req_rs1(req_rs1),
    .req_tag(req_tag), .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty),
    .unlock_valid(unlock_valid), .unlock_wid(unlock_wid),
    .csr_rd_en(csr_rd_en), .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_idx(rsp_idx)
  );

  always #5 clk = ~clk;

  // CSR store stand-in: data valid only the cycle after the strobe, garbage otherwise.
  always @(posedge clk) csr_rd_data <= csr_rd_en ? cur_init : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (csr_wr_en)    wr_cnt  <= wr_cnt + 1;
    if (unlock_valid) unl_cnt <= unl_cnt + 1;
  end

  typedef struct {
    int          ch;
    logic [11:0] addr;
    logic [1:0]  op;
    logic        ui;
    logic [4:0]  imm;
    logic [31:0] rs1;
    logic [31:0] init;
    logic        wen;
    logic [31:0] wdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int ch, input logic [11:0] addr, input logic [1:0] op,
                           input logic ui, input logic [4:0] imm, input logic [31:0] rs1,
                           input logic [15:0] tag, input logic [1:0] wid);
    req_valid[ch]   = 1'b1;
    req_addr[ch]    = addr;
    req_op[ch]      = op;
    req_use_imm[ch] = ui;
    req_imm[ch]     = imm;
    req_rs1[ch]     = rs1;
    req_tag[ch]     = tag;
    req_wid[ch]     = wid;
  endtask

  task automatic wait_accept(input int ch, input string nm);
    int n = 0;
    logic [1:0] exp = 2'b00;
    exp[ch] = 1'b1;
    #1;
    while (req_ready[ch] !== 1'b1 && n < 20) begin
      step();
      #1;
      n++;
    end
    chk(nm, 32'(req_ready), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt [6];
    logic [1:0]  gr [4];
    int          gc [4];
    logic [0:0]  ri [4];
    logic [15:0] rt [4];
    int          ng, nr, cyc, w0, u0;

    vt[0] = '{0, 12'h300, 2'b01, 1'b0, 5'd0,  32'h0000_00F0, 32'h0000_000F, 1'b1, 32'h0000_00FF};
    vt[1] = '{1, 12'h305, 2'b10, 1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0000_AA55, 1'b0, 32'h0};
    vt[2] = '{0, 12'h340, 2'b00, 1'b0, 5'd0,  32'h0,         32'h0000_1234, 1'b1, 32'h0};
    vt[3] = '{1, 12'h341, 2'b10, 1'b0, 5'd0,  32'h0000_0F0F, 32'h0000_FFFF, 1'b1, 32'h0000_F0F0};
    vt[4] = '{0, 12'h342, 2'b01, 1'b1, 5'h1F, 32'hFFFF_FFFF, 32'h0000_0100, 1'b1, 32'h0000_011F};
    vt[5] = '{1, 12'h7C0, 2'b11, 1'b0, 5'd0,  32'h0000_0001, 32'h0000_0003, 1'b1, 32'h0000_0002};

    reset = 1'b1; req_valid = '0; req_wid = '0; req_addr = '0; req_op = '0;
    req_use_imm = '0; req_imm = '0; req_rs1 = '0; req_tag = '0;
    alm_empty = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin gr[i] = '0; gc[i] = 0; ri[i] = '0; rt[i] = '0; end
    step(); step(); #1;
    chk("rst_req_ready",  32'(req_ready), 32'd0);
    chk("rst_rd_en",      32'(csr_rd_en), 32'd0);
    chk("rst_wr_en",      32'(csr_wr_en), 32'd0);
    chk("rst_unlock",     32'(unlock_valid), 32'd0);
    chk("rst_rsp_valid",  32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",   rsp_data, 32'd0);
    chk("rst_wr_data",    csr_wr_data, 32'd0);
    chk("rst_alm_wid",    32'(alm_empty_wid), 32'd0);
    reset = 1'b0;
    step();

    // Single requests from the table.
    for (int i = 0; i < 6; i++) begin
      cur_init = vt[i].init;
      drive_req(vt[i].ch, vt[i].addr, vt[i].op, vt[i].ui, vt[i].imm, vt[i].rs1,
                16'hA000 + 16'(i), 2'd0);
      wait_accept(vt[i].ch, "vec_accept");
      step(); req_valid = '0; #1;
      chk("vec_rd_en",   32'(csr_rd_en), 32'd1);
      chk("vec_rd_addr", 32'(csr_rd_addr), 32'(vt[i].addr));
      chk("vec_wr_early", 32'(csr_wr_en), 32'd0);
      step(); #1;
      chk("vec_wr_en", 32'(csr_wr_en), 32'(vt[i].wen));
      if (vt[i].wen) begin
        chk("vec_wr_data", csr_wr_data, vt[i].wdata);
        chk("vec_wr_addr", 32'(csr_wr_addr), 32'(vt[i].addr));
      end
      chk("vec_rsp_early", 32'(rsp_valid), 32'd0);
      step(); #1;
      chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("vec_rsp_data",  rsp_data, vt[i].init);
      chk("vec_rsp_tag",   32'(rsp_tag), 32'(16'hA000 + 16'(i)));
      chk("vec_rsp_idx",   32'(rsp_idx), 32'(vt[i].ch));
      step();
    end

    // Both channels continuously valid: grants alternate, 3 cycles apart.
    cur_init = 32'h5;
    drive_req(0, 12'h300, 2'b01, 1'b0, 5'd0, 32'h0, 16'hC000, 2'd0);
    drive_req(1, 12'h301, 2'b01, 1'b0, 5'd0, 32'h0, 16'hC001, 2'd1);
    ng = 0; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 60) begin
      #1;
      if (req_ready != 2'b00 && ng < 4) begin gr[ng] = req_ready; gc[ng] = cyc; ng++; end
      if (rsp_valid) begin ri[nr] = rsp_idx; rt[nr] = rsp_tag; nr++; end
      step(); cyc++;
      if (ng == 4) req_valid = '0;
    end
    chk("rr_rsp_count", 32'(nr), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant",   32'(gr[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rsp_idx", 32'(ri[k]), 32'(k % 2));
      chk("rr_rsp_tag", 32'(rt[k]), 32'(16'hC000 + 16'(k % 2)));
      if (k > 0) chk("rr_spacing", 32'(gc[k] - gc[k-1]), 32'd3);
    end
    step();

`ifdef CSR_FENCE_EN
    cur_init = 32'h0;
    u0 = unl_cnt;
    drive_req(0, 12'h001, 2'b01, 1'b0, 5'd0, 32'h1, 16'hF000, 2'd2);
    wait_accept(0, "fence_accept");
    step(); req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("fence_rd_wait", 32'(csr_rd_en), 32'd0);
      chk("fence_wid",     32'(alm_empty_wid), 32'd2);
      step();
    end
    alm_empty = 1'b1; #1;
    chk("fence_rd_rise", 32'(csr_rd_en), 32'd0);
    step(); #1;
    chk("fence_rd_en",   32'(csr_rd_en), 32'd1);
    step(); #1;
    chk("fence_unlock",     32'(unlock_valid), 32'd1);
    chk("fence_unlock_wid", 32'(unlock_wid), 32'd2);
    chk("fence_wr_data",    csr_wr_data, 32'h1);
    step(); alm_empty = 1'b0; #1;
    chk("fence_unlock_off", 32'(unlock_valid), 32'd0);
    chk("fence_rsp_tag",    32'(rsp_tag), 32'hF000);
    step();
    chk("fence_unlock_cnt", 32'(unl_cnt - u0), 32'd1);
`else
    cur_init = 32'h0;
    u0 = unl_cnt;
    drive_req(0, 12'h001, 2'b01, 1'b0, 5'd0, 32'h1, 16'hF000, 2'd2);
    wait_accept(0, "nofence_accept");
    step(); req_valid = '0; #1;
    chk("nofence_rd_en",   32'(csr_rd_en), 32'd1);
    chk("nofence_alm_wid", 32'(alm_empty_wid), 32'd0);
    step(); #1;
    chk("nofence_wr_en",  32'(csr_wr_en), 32'd1);
    chk("nofence_unlock", 32'(unlock_valid), 32'd0);
    step(); #1;
    chk("nofence_rsp_tag", 32'(rsp_tag), 32'hF000);
    step();
    chk("nofence_unlock_cnt", 32'(unl_cnt - u0), 32'd0);
`endif

    // FIFO full: four responses parked, fifth request waits in EXEC.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cur_init = 32'h50 + 32'(k);
      drive_req(0, 12'h310, 2'b00, 1'b0, 5'd0, 32'(k + 1), 16'hD000 + 16'(k), 2'd0);
      wait_accept(0, "full_fill_accept");
      step(); req_valid = '0;
      step(); step();
    end
    cur_init = 32'h54;
    drive_req(0, 12'h310, 2'b00, 1'b0, 5'd0, 32'h5, 16'hD004, 2'd0);
    wait_accept(0, "full_accept");
    w0 = wr_cnt;
    step(); req_valid = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("full_hold_no_wr", 32'(csr_wr_en), 32'd0);
      step();
    end
    rsp_ready = 1'b1; #1;
    chk("full_head_tag", 32'(rsp_tag), 32'hD000);
    chk("full_pop_no_wr", 32'(csr_wr_en), 32'd0);
    step(); rsp_ready = 1'b0; #1;
    chk("full_release_wr", 32'(csr_wr_en), 32'd1);
    chk("full_release_dat", csr_wr_data, 32'h5);
    step(); #1;
    chk("full_single_wr", 32'(csr_wr_en), 32'd0);
    chk("full_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    rsp_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      #1;
      chk("full_drain_tag",  32'(rsp_tag), 32'(16'hD000 + 16'(k)));
      chk("full_drain_data", rsp_data, 32'h50 + 32'(k));
      step();
    end
    #1;
    chk("full_drain_empty", 32'(rsp_valid), 32'd0);
    step();

    // Reset while in EXEC.
    cur_init = 32'h77;
    w0 = wr_cnt; u0 = unl_cnt;
    drive_req(0, 12'h320, 2'b00, 1'b0, 5'd0, 32'h9, 16'hE000, 2'd1);
    wait_accept(0, "rst_exec_accept");
    step(); req_valid = '0;
    step();
    reset = 1'b1; #1;
    chk("rst_exec_wr_en", 32'(csr_wr_en), 32'd0);
    step(); step();
    reset = 1'b0; #1;
    chk("rst_exec_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_exec_wr_cnt", 32'(wr_cnt - w0), 32'd0);
    step();

`ifdef CSR_FENCE_EN
    drive_req(0, 12'h002, 2'b00, 1'b0, 5'd0, 32'h3, 16'hE100, 2'd3);
    wait_accept(0, "rst_fence_accept");
    step(); req_valid = '0;
    step();
    reset = 1'b1; alm_empty = 1'b1; #1;
    chk("rst_fence_wid", 32'(alm_empty_wid), 32'd0);
    step(); step();
    reset = 1'b0; alm_empty = 1'b0; #1;
    chk("rst_fence_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_fence_unl_cnt", 32'(unl_cnt - u0), 32'd0);
    chk("rst_fence_wr_cnt",  32'(wr_cnt - w0), 32'd0);
    step();
`endif

    // After reset channel 0 must win and complete normally.
    cur_init = 32'h0F;
    drive_req(0, 12'h300, 2'b01, 1'b0, 5'd0, 32'hF0, 16'hB000, 2'd0);
    drive_req(1, 12'h301, 2'b01, 1'b0, 5'd0, 32'hF0, 16'hB001, 2'd0);
    wait_accept(0, "post_rst_grant");
    step(); req_valid = '0; #1;
    chk("post_rst_rd_en", 32'(csr_rd_en), 32'd1);
    step(); #1;
    chk("post_rst_wr_data", csr_wr_data, 32'hFF);
    step(); #1;
    chk("post_rst_rsp_data", rsp_data, 32'h0F);
    chk("post_rst_rsp_idx",  32'(rsp_idx), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
